instr_encoder: RTL

- Streaming RV32I instruction encoder: the inverse of the instruction field decoder.
- Accepts field-level requests (format, opcode, funct3/funct7, register indices, 32-bit immediate) over a valid/ready handshake.
- Packs each request into a 32-bit instruction word, flags immediates that the chosen format cannot represent, and queues the results in a small output FIFO.
- Used by the self-test instruction generator and bench stimulus paths to feed fetch/decode.

---
 rtl/instr_pkg.sv | 35 +++
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_fifo.sv | 46 ++++
 rtl/instr_encoder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared RV32I field definitions for the instruction encoder and decoder.
// Holds the format enum, common opcodes, field bit positions and an immediate-range helper.
package instr_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    // True when bits [31:msb] of v are all equal, i.e. v is a sign extension from bit msb.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> msb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and result channels of the instruction encoder.
// The master drives field-level requests and consumes encoded words; the slave is the encoder.
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_op;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_op, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_op, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with wrap-bit pointers; reads zero while empty.
// Push/pop requests are ignored when full/empty respectively.
module instr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with an output queue and request/error counters.
// Unrepresentable immediates are still packed (truncated) and tagged with an error bit.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    instr_encoder_if.slave    bus,
    output logic [CNT_W-1:0]  enc_count,
    output logic [7:0]        err_count
);

    function automatic logic [32:0] encode(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] word;
        logic        err;
        word = '0;
        err  = 1'b0;
        word[OP_LSB +: 7] = op;
        case (fmt_e'(fmt))
            FMT_R: begin
                word[RD_LSB  +: 5] = rd;
                word[F3_LSB  +: 3] = f3;
                word[RS1_LSB +: 5] = rs1;
                word[RS2_LSB +: 5] = rs2;
                word[F7_LSB  +: 7] = f7;
            end
            FMT_I: begin
                word[RD_LSB  +: 5] = rd;
                word[F3_LSB  +: 3] = f3;
                word[RS1_LSB +: 5] = rs1;
                word[31:20]        = imm[11:0];
                err                = !fits_signed(imm, 11);
            end
            FMT_S: begin
                word[F3_LSB  +: 3] = f3;
                word[RS1_LSB +: 5] = rs1;
                word[RS2_LSB +: 5] = rs2;
                word[31:25]        = imm[11:5];
                word[11:7]         = imm[4:0];
                err                = !fits_signed(imm, 11);
            end
            FMT_B: begin
                word[F3_LSB  +: 3] = f3;
                word[RS1_LSB +: 5] = rs1;
                word[RS2_LSB +: 5] = rs2;
                word[31]           = imm[12];
                word[30:25]        = imm[10:5];
                word[11:8]         = imm[4:1];
                word[7]            = imm[11];
                err                = imm[0] || !fits_signed(imm, 12);
            end
            FMT_U: begin
                word[RD_LSB +: 5] = rd;
                word[31:12]       = imm[31:12];
                err               = |imm[11:0];
            end
            FMT_J: begin
                word[RD_LSB +: 5] = rd;
                word[31]          = imm[20];
                word[30:21]       = imm[10:1];
                word[20]          = imm[11];
                word[19:12]       = imm[19:12];
                err               = imm[0] || !fits_signed(imm, 20);
            end
            default: begin
                word = '0;
                err  = 1'b1;
            end
        endcase
        return {err, word};
    endfunction

    logic [32:0] enc_entry;
    logic [32:0] head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        pop;

    assign enc_entry = encode(bus.in_fmt, bus.in_op, bus.in_funct3, bus.in_funct7,
                              bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);

    // Ready depends only on queue occupancy, never on the consumer's out_ready.
    assign bus.in_ready  = !fifo_full;
    assign accept        = bus.in_valid && !fifo_full;
    assign bus.out_valid = !fifo_empty;
    assign pop           = bus.out_ready && !fifo_empty;
    assign bus.out_instr = head[31:0];
    assign bus.out_err   = head[32];

    instr_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (enc_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (accept) begin
            enc_count <= enc_count + 1'b1;
            if (enc_entry[32] && (err_count != 8'hFF)) err_count <= err_count + 1'b1;
        end
    end

endmodule
